// File: rtl/cpu_sram_arbiter_if.sv
// Sram-like request/response port shared by the fetch, data and bus sides.
interface cpu_sram_arbiter_if;
  logic        request;
  logic        write;
  logic [1:0]  size;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic [31:0] read_data;
  logic        address_ready;
  logic        data_ready;

  // Side that issues requests and consumes responses
  modport master (
    output request, write, size, address, write_data, write_strobe,
    input  read_data, address_ready, data_ready
  );

  // Side that accepts requests and produces responses
  modport slave (
    input  request, write, size, address, write_data, write_strobe,
    output read_data, address_ready, data_ready
  );
endinterface

// File: rtl/cpu_sram_arbiter.sv
// Arbitrates the fetch and data sram-like masters onto one bus port.
// Data has fixed priority; a grant is locked while the bus stalls the
// request, and an in-order owner FIFO routes each response back.
module cpu_sram_arbiter #(
  parameter int unsigned OUTSTANDING_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  cpu_sram_arbiter_if.slave    instruction_ram,
  cpu_sram_arbiter_if.slave    data_ram,
  cpu_sram_arbiter_if.master   bus_ram
);

  localparam int unsigned PTR_W = $clog2(OUTSTANDING_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;
  typedef enum logic {LOCK_IDLE = 1'b0, LOCK_HELD = 1'b1} lock_e;

  lock_e              lock_state_q, lock_state_d;
  owner_e             lock_owner_q, lock_owner_d;
  owner_e             winner;
  owner_e             head_owner;
  owner_e             owner_fifo_q [OUTSTANDING_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               win_req;
  logic               full;
  logic               bus_req;
  logic               accept;
  logic               pop;
  logic               unused_inst_fields;

  // The fetch master is read-only; its write-side fields are ignored.
  assign unused_inst_fields = ^{instruction_ram.write, instruction_ram.size,
                                instruction_ram.write_data, instruction_ram.write_strobe};

  // Pick the winner and forward its request fields to the bus
  always_comb begin
    winner = OWN_INST;
    if (lock_state_q == LOCK_HELD) begin
      winner = lock_owner_q;
    end else if (data_ram.request) begin
      winner = OWN_DATA;
    end
    win_req = (winner == OWN_DATA) ? data_ram.request : instruction_ram.request;
    full    = (count_q == CNT_W'(OUTSTANDING_DEPTH));
    bus_req = win_req && !full && !reset;
    accept  = bus_req && bus_ram.address_ready;

    bus_ram.request      = bus_req;
    bus_ram.write        = 1'b0;
    bus_ram.size         = 2'b10;
    bus_ram.address      = instruction_ram.address;
    bus_ram.write_data   = '0;
    bus_ram.write_strobe = '0;
    if (winner == OWN_DATA) begin
      bus_ram.write        = data_ram.write;
      bus_ram.size         = data_ram.size;
      bus_ram.address      = data_ram.address;
      bus_ram.write_data   = data_ram.write_data;
      bus_ram.write_strobe = data_ram.write_strobe;
    end
  end

  // Lock next state: hold the grant only while the bus stalls our request;
  // a dropped request or an accept both fall through to LOCK_IDLE.
  always_comb begin
    lock_state_d = LOCK_IDLE;
    lock_owner_d = lock_owner_q;
    if (bus_req && !bus_ram.address_ready) begin
      lock_state_d = LOCK_HELD;
      lock_owner_d = winner;
    end
  end

  // Lock state register
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_state_q <= LOCK_IDLE;
      lock_owner_q <= OWN_INST;
    end else begin
      lock_state_q <= lock_state_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  // Owner FIFO pointer and occupancy update
  always_comb begin
    head_owner = owner_fifo_q[rd_ptr_q];
    pop        = !reset && bus_ram.data_ready && (count_q != '0);
    wr_ptr_d   = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(accept) - CNT_W'(pop);
  end

  // Owner FIFO pointers and count
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Owner FIFO storage; contents are meaningless while count is zero
  always_ff @(posedge clock) begin
    if (accept) begin
      owner_fifo_q[wr_ptr_q] <= winner;
    end
  end

  // Flag a bus response arriving with nothing outstanding
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(bus_ram.data_ready && (count_q == '0)))
        else $error("bus_ram_data_ready with no outstanding transaction");
    end
  end

  assign instruction_ram.address_ready = accept && (winner == OWN_INST);
  assign data_ram.address_ready        = accept && (winner == OWN_DATA);
  assign instruction_ram.data_ready    = pop && (head_owner == OWN_INST);
  assign data_ram.data_ready           = pop && (head_owner == OWN_DATA);
  assign instruction_ram.read_data     = bus_ram.read_data;
  assign data_ram.read_data            = bus_ram.read_data;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed bench for cpu_sram_arbiter with hand-computed expectations.
module tb_cpu_sram_arbiter;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  cpu_sram_arbiter_if inst_if ();
  cpu_sram_arbiter_if data_if ();
  cpu_sram_arbiter_if bus_if  ();

  cpu_sram_arbiter #(.OUTSTANDING_DEPTH(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .instruction_ram (inst_if),
    .data_ram        (data_if),
    .bus_ram         (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    inst_if.request       = 1'b0;
    inst_if.write         = 1'b0;
    inst_if.size          = 2'b10;
    inst_if.address       = '0;
    inst_if.write_data    = '0;
    inst_if.write_strobe  = '0;
    data_if.request       = 1'b0;
    data_if.write         = 1'b0;
    data_if.size          = 2'b10;
    data_if.address       = '0;
    data_if.write_data    = '0;
    data_if.write_strobe  = '0;
    bus_if.read_data      = '0;
    bus_if.address_ready  = 1'b0;
    bus_if.data_ready     = 1'b0;
  endtask

  task automatic check_readies(input string tag, input logic iar, input logic dar,
                               input logic idr, input logic ddr);
    check_eq({tag, "_inst_ar"}, 32'(inst_if.address_ready), 32'(iar));
    check_eq({tag, "_data_ar"}, 32'(data_if.address_ready), 32'(dar));
    check_eq({tag, "_inst_dr"}, 32'(inst_if.data_ready),    32'(idr));
    check_eq({tag, "_data_dr"}, 32'(data_if.data_ready),    32'(ddr));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    step();
    reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    drive_idle();

    // Reset cycle with every request and bus strobe active
    #1;
    inst_if.request      = 1'b1;
    data_if.request      = 1'b1;
    bus_if.address_ready = 1'b1;
    bus_if.data_ready    = 1'b1;
    settle();
    check_eq("rst_bus_req", 32'(bus_if.request), 32'd0);
    check_readies("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    drive_idle();
    settle();
    check_eq("rst_count", 32'(dut.count_q), 32'd0);

    // Both request together, bus always ready, one-cycle responses
    step();
    inst_if.request = 1'b1; inst_if.address = 32'h0000_0100;
    data_if.request = 1'b1; data_if.address = 32'h0000_0200;
    bus_if.address_ready = 1'b1;
    settle();
    check_eq("pri_c0_req",  32'(bus_if.request), 32'd1);
    check_eq("pri_c0_addr", bus_if.address, 32'h0000_0200);
    check_readies("pri_c0", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    data_if.request = 1'b0; data_if.write_data = 32'h1234_5678;
    data_if.write_strobe = 4'hf; data_if.write = 1'b1; data_if.size = 2'b00;
    bus_if.data_ready = 1'b1; bus_if.read_data = 32'haaaa_0001;
    settle();
    check_eq("pri_c1_addr",  bus_if.address, 32'h0000_0100);
    check_eq("pri_c1_write", 32'(bus_if.write), 32'd0);
    check_eq("pri_c1_size",  32'(bus_if.size), 32'd2);
    check_eq("pri_c1_wdata", bus_if.write_data, 32'd0);
    check_eq("pri_c1_strb",  32'(bus_if.write_strobe), 32'd0);
    check_eq("pri_c1_rdata", data_if.read_data, 32'haaaa_0001);
    check_readies("pri_c1", 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    drive_idle();
    bus_if.data_ready = 1'b1; bus_if.read_data = 32'hbbbb_0002;
    settle();
    check_eq("pri_c2_req",   32'(bus_if.request), 32'd0);
    check_eq("pri_c2_rdata", inst_if.read_data, 32'hbbbb_0002);
    check_readies("pri_c2", 1'b0, 1'b0, 1'b1, 1'b0);

    // Fetch stalled by the bus keeps its grant against a data request
    step();
    drive_idle();
    inst_if.request = 1'b1; inst_if.address = 32'hbfc0_0000;
    settle();
    check_eq("lock_c0_req",  32'(bus_if.request), 32'd1);
    check_eq("lock_c0_addr", bus_if.address, 32'hbfc0_0000);
    check_readies("lock_c0", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      step();
      data_if.request = 1'b1; data_if.address = 32'h0000_0300;
      settle();
      check_eq($sformatf("lock_c%0d_addr", c), bus_if.address, 32'hbfc0_0000);
      check_readies($sformatf("lock_c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step();
    bus_if.address_ready = 1'b1;
    settle();
    check_eq("lock_c3_addr", bus_if.address, 32'hbfc0_0000);
    check_readies("lock_c3", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    inst_if.request = 1'b0;
    settle();
    check_eq("lock_c4_addr", bus_if.address, 32'h0000_0300);
    check_readies("lock_c4", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    bus_if.data_ready = 1'b1; bus_if.read_data = 32'h0000_0005;
    settle();
    check_readies("lock_c5", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    bus_if.read_data = 32'h0000_0006;
    settle();
    check_readies("lock_c6", 1'b0, 1'b0, 1'b0, 1'b1);

    // Response routing for accept order I, D, I
    step();
    drive_idle();
    bus_if.address_ready = 1'b1;
    inst_if.request = 1'b1; inst_if.address = 32'h0000_0010;
    settle();
    check_readies("ord_c0", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    inst_if.request = 1'b0;
    data_if.request = 1'b1; data_if.address = 32'h0000_0020;
    settle();
    check_readies("ord_c1", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    data_if.request = 1'b0;
    inst_if.request = 1'b1; inst_if.address = 32'h0000_0030;
    settle();
    check_readies("ord_c2", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive_idle();
    bus_if.data_ready = 1'b1; bus_if.read_data = 32'h0000_0011;
    settle();
    check_eq("ord_c3_rdata", inst_if.read_data, 32'h0000_0011);
    check_readies("ord_c3", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    bus_if.read_data = 32'h0000_0022;
    settle();
    check_eq("ord_c4_rdata", data_if.read_data, 32'h0000_0022);
    check_readies("ord_c4", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    bus_if.read_data = 32'h0000_0033;
    settle();
    check_eq("ord_c5_rdata", inst_if.read_data, 32'h0000_0033);
    check_readies("ord_c5", 1'b0, 1'b0, 1'b1, 1'b0);

    // Fill all four slots, then show the full stall and pop without bypass
    step();
    drive_idle();
    bus_if.address_ready = 1'b1;
    data_if.request = 1'b1; data_if.address = 32'h0000_0400;
    settle();
    check_readies("full_c0", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      step();
      settle();
      check_readies($sformatf("full_c%0d", c), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step();
    settle();
    check_eq("full_c4_req", 32'(bus_if.request), 32'd0);
    check_readies("full_c4", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    bus_if.data_ready = 1'b1; bus_if.read_data = 32'h0000_0041;
    settle();
    check_eq("full_c5_req", 32'(bus_if.request), 32'd0);
    check_readies("full_c5", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    bus_if.data_ready = 1'b0;
    settle();
    check_eq("full_c6_req", 32'(bus_if.request), 32'd1);
    check_readies("full_c6", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    data_if.request = 1'b0;
    bus_if.data_ready = 1'b1;
    for (int c = 7; c <= 10; c++) begin
      settle();
      check_readies($sformatf("full_c%0d", c), 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    drive_idle();

    // Data write fields pass through; the ack goes only to data
    settle();
    inst_if.request = 1'b1; inst_if.address = 32'h0000_0500;
    data_if.request = 1'b1; data_if.write = 1'b1; data_if.size = 2'b10;
    data_if.address = 32'h1fc0_0010; data_if.write_data = 32'hdead_beef;
    data_if.write_strobe = 4'b0011;
    bus_if.address_ready = 1'b1;
    settle();
    check_eq("wr_write", 32'(bus_if.write), 32'd1);
    check_eq("wr_size",  32'(bus_if.size), 32'd2);
    check_eq("wr_addr",  bus_if.address, 32'h1fc0_0010);
    check_eq("wr_wdata", bus_if.write_data, 32'hdead_beef);
    check_eq("wr_strb",  32'(bus_if.write_strobe), 32'h3);
    check_readies("wr_c0", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    bus_if.data_ready = 1'b1;
    settle();
    check_readies("wr_ack", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset with two outstanding and a held lock clears everything
    step();
    drive_idle();
    bus_if.address_ready = 1'b1;
    inst_if.request = 1'b1; inst_if.address = 32'h0000_0600;
    settle();
    check_readies("rs_c0", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    inst_if.request = 1'b0;
    data_if.request = 1'b1; data_if.address = 32'h0000_0700;
    settle();
    check_readies("rs_c1", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    data_if.request = 1'b0;
    inst_if.request = 1'b1; inst_if.address = 32'h0000_0800;
    bus_if.address_ready = 1'b0;
    settle();
    check_eq("rs_c2_count", 32'(dut.count_q), 32'd2);
    step();
    reset = 1'b1;
    bus_if.address_ready = 1'b1;
    bus_if.data_ready = 1'b1;
    settle();
    check_eq("rs_c3_req", 32'(bus_if.request), 32'd0);
    check_readies("rs_c3", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    drive_idle();
    settle();
    check_eq("rs_c4_count", 32'(dut.count_q), 32'd0);
    check_eq("rs_c4_lock",  32'(dut.lock_state_q), 32'd0);
    data_if.request = 1'b1; data_if.address = 32'h0000_0900;
    bus_if.address_ready = 1'b1;
    settle();
    check_readies("rs_c4", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    bus_if.data_ready = 1'b1;
    settle();
    check_readies("rs_c5", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive_idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
